// File: rtl/cmp_qual_pkg.sv
// Shared types and constants for the comparator qualifier slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_qual_pkg;

    // Width of the run-length counter used by the rise and fall checks
    localparam int RUN_W = 8;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } qual_state_t;

endpackage

// File: rtl/cmp_run_counter.sv
// Run-length counter with a limit compare, shared by the rise and fall checks.
// Latency: run updates on the clock edge; hit is combinational from run and limit.
// Backpressure: none; hold freezes the count.
module cmp_run_counter
    import cmp_qual_pkg::*;
#(
    parameter int W = RUN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] run,
    output logic         hit
);

    localparam logic [W-1:0] ONE = 1;

    // hit means the sample being taken now would complete the run
    assign hit = ((run + ONE) == limit);

    // Run-length register: hold wins, then clear, then load of 1, then increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= '0;
        end else if (hold) begin
            run <= run;
        end else if (clr) begin
            run <= '0;
        end else if (load1) begin
            run <= ONE;
        end else if (inc) begin
            run <= run + ONE;
        end
    end

endmodule

// File: rtl/cmp_gt_qualifier.sv
// Debounces the comparator gt bit and reports qualified rising events; GT_QUAL_SAT_EN makes evt_cnt saturate and drives ovf.
// Latency: gt_q/rise_pulse/evt_* register on the edge sampling the HOLD_CYCLES-th high (REL_CYCLES-th low for release).
// Backpressure: one-deep evt_valid/evt_ready; an event arriving while one is pending and not accepted sets sticky evt_miss.
module cmp_gt_qualifier
    import cmp_qual_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int REL_CYCLES  = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             gt,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             gt_q,
    output logic             rise_pulse,
    output logic             evt_valid,
    output logic             evt_miss,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf
);

    localparam logic [RUN_W-1:0] HOLD_L = RUN_W'(HOLD_CYCLES);
    localparam logic [RUN_W-1:0] REL_L  = RUN_W'(REL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    qual_state_t      state;
    qual_state_t      state_nxt;
    logic             qual;
    logic             run_inc;
    logic             run_load1;
    logic             run_clr;
    logic             run_hit;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_limit;

    // The same counter serves both checks; only FALL_CHK measures against the release length
    assign run_limit = (state == FALL_CHK) ? REL_L : HOLD_L;

    cmp_run_counter #(
        .W (RUN_W)
    ) u_run (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (!sample_en),
        .clr   (run_clr),
        .load1 (run_load1),
        .inc   (run_inc),
        .limit (run_limit),
        .run   (run),
        .hit   (run_hit)
    );

    // Next-state and run-counter control; nothing moves while sampling is paused
    always_comb begin
        state_nxt = state;
        qual      = 1'b0;
        run_inc   = 1'b0;
        run_load1 = 1'b0;
        run_clr   = 1'b0;
        if (sample_en) begin
            case (state)
                LOW: begin
                    if (gt) begin
                        if (HOLD_CYCLES == 1) begin
                            state_nxt = HIGH;
                            run_clr   = 1'b1;
                            qual      = 1'b1;
                        end else begin
                            state_nxt = RISE_CHK;
                            run_load1 = 1'b1;
                        end
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                RISE_CHK: begin
                    if (gt) begin
                        if (run_hit) begin
                            state_nxt = HIGH;
                            run_clr   = 1'b1;
                            qual      = 1'b1;
                        end else begin
                            run_inc = 1'b1;
                        end
                    end else begin
                        state_nxt = LOW;
                        run_clr   = 1'b1;
                    end
                end
                HIGH: begin
                    if (!gt) begin
                        if (REL_CYCLES == 1) begin
                            state_nxt = LOW;
                            run_clr   = 1'b1;
                        end else begin
                            state_nxt = FALL_CHK;
                            run_load1 = 1'b1;
                        end
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                default: begin
                    if (!gt) begin
                        if (run_hit) begin
                            state_nxt = LOW;
                            run_clr   = 1'b1;
                        end else begin
                            run_inc = 1'b1;
                        end
                    end else begin
                        // Bounce during release: back to HIGH without a new event
                        state_nxt = HIGH;
                        run_clr   = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM state with registered filtered output and rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOW;
            gt_q       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            gt_q       <= (state_nxt == HIGH) || (state_nxt == FALL_CHK);
            rise_pulse <= qual;
        end
    end

    // One-deep event handshake; a new event refills the slot even if it is being accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_miss  <= 1'b0;
        end else begin
            if (qual) begin
                evt_valid <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (clr) begin
                evt_miss <= 1'b0;
            end else if (qual && evt_valid && !evt_ready) begin
                evt_miss <= 1'b1;
            end
        end
    end

`ifdef GT_QUAL_SAT_EN
    // Event counter saturates at all-ones; further events raise sticky ovf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            evt_cnt <= '0;
            ovf     <= 1'b0;
        end else if (qual) begin
            if (&evt_cnt) begin
                ovf <= 1'b1;
            end else begin
                evt_cnt <= evt_cnt + CNT_ONE;
            end
        end
    end
`else
    // Event counter wraps modulo 2^CNT_W; overflow is not tracked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (clr) begin
            evt_cnt <= '0;
        end else if (qual) begin
            evt_cnt <= evt_cnt + CNT_ONE;
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_gt_qualifier.sv
// Self-checking bench for cmp_gt_qualifier with a run-length reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: evt_ready driven directly, both held low and randomised.
module tb_cmp_gt_qualifier;

    localparam int HOLD  = 3;
    localparam int REL   = 2;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             sample_en;
    logic             gt;
    logic             clr;
    logic             evt_ready;
    logic             gt_q;
    logic             rise_pulse;
    logic             evt_valid;
    logic             evt_miss;
    logic [CNT_W-1:0] evt_cnt;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: consecutive-sample counts rather than FSM states
    int   m_hi, m_lo, m_cnt;
    logic m_q, m_rise, m_vld, m_miss, m_ovf;

    cmp_gt_qualifier #(
        .HOLD_CYCLES (HOLD),
        .REL_CYCLES  (REL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .gt         (gt),
        .clr        (clr),
        .evt_ready  (evt_ready),
        .gt_q       (gt_q),
        .rise_pulse (rise_pulse),
        .evt_valid  (evt_valid),
        .evt_miss   (evt_miss),
        .evt_cnt    (evt_cnt),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_cnt = 0;
        m_q = 0; m_rise = 0; m_vld = 0; m_miss = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic g, input logic en, input logic rdy, input logic c);
        logic q_now;
        q_now = 1'b0;
        if (en) begin
            if (!m_q) begin
                m_hi = g ? m_hi + 1 : 0;
                if (m_hi >= HOLD) begin
                    m_q = 1'b1; q_now = 1'b1; m_hi = 0; m_lo = 0;
                end
            end else begin
                m_lo = !g ? m_lo + 1 : 0;
                if (m_lo >= REL) begin
                    m_q = 1'b0; m_hi = 0; m_lo = 0;
                end
            end
        end
        m_rise = q_now;
        if (c) m_miss = 1'b0;
        else if (q_now && m_vld && !rdy) m_miss = 1'b1;
        if (q_now) m_vld = 1'b1;
        else if (m_vld && rdy) m_vld = 1'b0;
        if (c) begin
            m_cnt = 0; m_ovf = 1'b0;
        end else if (q_now) begin
`ifdef GT_QUAL_SAT_EN
            if (m_cnt == MAXC) m_ovf = 1'b1;
            else m_cnt = m_cnt + 1;
`else
            m_cnt = (m_cnt + 1) % (MAXC + 1);
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gt_q"},       32'(gt_q),       32'(m_q));
        chk({tag, ".rise_pulse"}, 32'(rise_pulse), 32'(m_rise));
        chk({tag, ".evt_valid"},  32'(evt_valid),  32'(m_vld));
        chk({tag, ".evt_miss"},   32'(evt_miss),   32'(m_miss));
        chk({tag, ".evt_cnt"},    32'(evt_cnt),    32'(m_cnt));
        chk({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
    endtask

    task automatic step(input string tag, input logic g, input logic en,
                        input logic rdy, input logic c);
        gt = g; sample_en = en; evt_ready = rdy; clr = c;
        @(posedge clk);
        model_edge(g, en, rdy, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b1; gt = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        model_reset();
        #3;
        do_reset("por");
        chk("por_cnt", 32'(evt_cnt), 32'd0);

        // Qualify after three highs
        step("q1", 1, 1, 0, 0);
        step("q2", 1, 1, 0, 0);
        chk("q2_gtq", 32'(gt_q), 32'd0);
        step("q3", 1, 1, 0, 0);
        chk("q3_gtq", 32'(gt_q), 32'd1);
        chk("q3_rise", 32'(rise_pulse), 32'd1);
        chk("q3_cnt", 32'(evt_cnt), 32'd1);
        chk("q3_vld", 32'(evt_valid), 32'd1);
        step("q4", 1, 1, 0, 0);
        chk("q4_rise", 32'(rise_pulse), 32'd0);

        // Release with a bounce, then full release
        step("r1", 0, 1, 0, 0);
        step("r2", 1, 1, 0, 0);
        chk("r2_gtq", 32'(gt_q), 32'd1);
        step("r3", 0, 1, 0, 0);
        chk("r3_gtq", 32'(gt_q), 32'd1);
        step("r4", 0, 1, 0, 0);
        chk("r4_gtq", 32'(gt_q), 32'd0);

        // Second qualification with the first event still pending -> miss
        for (int i = 0; i < 3; i++) step("rq", 1, 1, 0, 0);
        chk("miss_flag", 32'(evt_miss), 32'd1);
        chk("miss_cnt", 32'(evt_cnt), 32'd2);
        chk("miss_vld", 32'(evt_valid), 32'd1);
        step("acc", 1, 1, 1, 0);
        chk("acc_vld", 32'(evt_valid), 32'd0);
        step("clr", 1, 1, 0, 1);
        chk("clr_cnt", 32'(evt_cnt), 32'd0);
        chk("clr_miss", 32'(evt_miss), 32'd0);
        chk("clr_gtq", 32'(gt_q), 32'd1);

        // Glitch in the rise check, then a paused qualification
        step("g0", 0, 1, 1, 0);
        step("g0", 0, 1, 1, 0);
        step("g1", 1, 1, 1, 0);
        step("g2", 1, 1, 1, 0);
        step("g3", 0, 1, 1, 0);
        step("g4", 1, 1, 1, 0);
        step("g5", 1, 1, 1, 0);
        chk("glitch_gtq", 32'(gt_q), 32'd0);
        chk("glitch_cnt", 32'(evt_cnt), 32'd0);
        for (int i = 0; i < 5; i++) step("pause", 1, 0, 1, 0);
        chk("pause_gtq", 32'(gt_q), 32'd0);
        step("resume", 1, 1, 1, 0);
        chk("resume_gtq", 32'(gt_q), 32'd1);
        chk("resume_cnt", 32'(evt_cnt), 32'd1);

        // Reset in the middle of a rise check
        step("m0", 0, 1, 0, 0);
        step("m0", 0, 1, 0, 0);
        step("m1", 1, 1, 0, 0);
        step("m2", 1, 1, 0, 0);
        do_reset("mid_rst");
        chk("mid_rst_cnt", 32'(evt_cnt), 32'd0);
        chk("mid_rst_vld", 32'(evt_valid), 32'd0);
        step("pr1", 1, 1, 0, 0);
        step("pr2", 1, 1, 0, 0);
        chk("post_rst_gtq", 32'(gt_q), 32'd0);
        step("pr3", 1, 1, 0, 0);
        chk("post_rst_q", 32'(gt_q), 32'd1);

        // Sixteen qualifications from zero to exercise the all-ones boundary
        step("oclr", 1, 1, 1, 1);
        for (int n = 0; n < 16; n++) begin
            step("of", 0, 1, 1, 0);
            step("of", 0, 1, 1, 0);
            for (int k = 0; k < 3; k++) step("oq", 1, 1, 1, 0);
        end
`ifdef GT_QUAL_SAT_EN
        chk("ovf_cnt", 32'(evt_cnt), 32'd15);
        chk("ovf_flag", 32'(ovf), 32'd1);
`else
        chk("ovf_cnt", 32'(evt_cnt), 32'd0);
        chk("ovf_flag", 32'(ovf), 32'd0);
`endif
        step("ovf_clr", 1, 1, 1, 1);
        chk("ovf_clr_flag", 32'(ovf), 32'd0);
        chk("ovf_clr_cnt", 32'(evt_cnt), 32'd0);

        // Randomised traffic with run-biased gt
        begin
            logic g;
            g = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) g = ~g;
                step("rnd", g, ($urandom_range(0, 7) != 0),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
